// File: rtl/riscv_pkg.sv
// Shared RV64 datapath definitions used by the register file and its read ports.
package riscv_pkg;

  localparam int XLEN       = 64;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = $clog2(NREGS);

  typedef logic [XLEN-1:0]       xlen_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: x0 zero-detect, storage mux and optional
// same-cycle forwarding of the write data.
module regfile_read_port
  import riscv_pkg::*;
#(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int NREGS  = riscv_pkg::NREGS,
  parameter bit BYPASS = 1'b0,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] regs [NREGS],
  input  logic            wr_active,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  output logic [XLEN-1:0] data
);

  // x0 always reads zero; otherwise forward the in-flight write when enabled,
  // falling back to the stored value.
  always_comb begin
    data = '0;
    if (addr != '0) begin
      if (BYPASS && wr_active && (addr == wr_addr)) begin
        data = wr_data;
      end else begin
        data = regs[addr];
      end
    end
  end

endmodule

// File: rtl/register_file.sv
// 32 x 64-bit RV64 integer register file: two combinational read ports and
// one synchronous write port, with x0 hardwired to zero.
module register_file
  import riscv_pkg::*;
#(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int NREGS  = riscv_pkg::NREGS,
  parameter bit BYPASS = 1'b0,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            write_enable,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_active;

  // A write only counts outside reset and never targets x0; the same qualifier
  // gates forwarding so reset and x0 writes are never visible on the ports.
  assign wr_active = write_enable && rst_n && (rd != '0);

  // Storage: async clear of every entry, then commit qualified writes on the
  // rising edge. Entry 0 is cleared on reset and never written afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_active) begin
      regs[rd] <= wd;
    end
  end

  regfile_read_port #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .BYPASS (BYPASS)
  ) u_port1 (
    .addr      (rs1),
    .regs      (regs),
    .wr_active (wr_active),
    .wr_addr   (rd),
    .wr_data   (wd),
    .data      (rd1)
  );

  regfile_read_port #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .BYPASS (BYPASS)
  ) u_port2 (
    .addr      (rs2),
    .regs      (regs),
    .wr_active (wr_active),
    .wr_addr   (rd),
    .wr_data   (wd),
    .data      (rd2)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file; drives one stimulus stream into a
// non-forwarding and a forwarding instance side by side.
module tb_register_file;

  logic        clk;
  logic        rst_n;
  logic        write_enable;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [63:0] wd;
  logic [63:0] rd1_b0, rd2_b0;
  logic [63:0] rd1_b1, rd2_b1;

  int checks;
  int errors;

  localparam logic [63:0] PAT_A = 64'hA5A5A5A5A5A5A5A5;
  localparam logic [63:0] PAT_5 = 64'h5A5A5A5A5A5A5A5A;
  localparam logic [63:0] ONES  = 64'hFFFFFFFFFFFFFFFF;

  register_file #(.BYPASS(1'b0)) dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_enable (write_enable),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .wd           (wd),
    .rd1          (rd1_b0),
    .rd2          (rd2_b0)
  );

  register_file #(.BYPASS(1'b1)) dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_enable (write_enable),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .wd           (wd),
    .rd1          (rd1_b1),
    .rd2          (rd2_b1)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic we, input logic [4:0] wa,
                               input logic [63:0] data,
                               input logic [4:0] a1, input logic [4:0] a2);
    write_enable = we;
    rd           = wa;
    wd           = data;
    rs1          = a1;
    rs2          = a2;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Directed sequence with hand-computed expectations.
  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    applyStimulus(1'b0, 5'd0, 64'h0, 5'd0, 5'd0);

    // Reset held for two edges, including an attempted write.
    applyStimulus(1'b1, 5'd4, ONES, 5'd4, 5'd4);
    tick();
    tick();
    checkOutput("reset_hold_b0", rd1_b0, 64'h0);
    checkOutput("reset_hold_b1", rd1_b1, 64'h0);
    applyStimulus(1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 5'd0, 64'h0, 5'(i), 5'(31 - i));
      checkOutput("reset_rd1_b0", rd1_b0, 64'h0);
      checkOutput("reset_rd2_b0", rd2_b0, 64'h0);
      checkOutput("reset_rd1_b1", rd1_b1, 64'h0);
      checkOutput("reset_rd2_b1", rd2_b1, 64'h0);
    end

    // Basic write then read.
    applyStimulus(1'b1, 5'd1, PAT_A, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 5'd1, 5'd0);
    checkOutput("basic_rd1_b0", rd1_b0, PAT_A);
    checkOutput("basic_rd2_b0", rd2_b0, 64'h0);
    checkOutput("basic_rd1_b1", rd1_b1, PAT_A);
    checkOutput("basic_rd2_b1", rd2_b1, 64'h0);

    // x0 write is discarded, and never forwarded.
    applyStimulus(1'b1, 5'd0, ONES, 5'd0, 5'd0);
    checkOutput("x0_fwd_b1", rd1_b1, 64'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 5'd0, 5'd1);
    checkOutput("x0_rd1_b0", rd1_b0, 64'h0);
    checkOutput("x0_rd1_b1", rd1_b1, 64'h0);
    checkOutput("x0_keep1_b0", rd2_b0, PAT_A);

    // Two ports, two entries.
    applyStimulus(1'b1, 5'd2, PAT_5, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 5'd2, 5'd1);
    checkOutput("indep_rd1_b0", rd1_b0, PAT_5);
    checkOutput("indep_rd2_b0", rd2_b0, PAT_A);
    checkOutput("indep_rd1_b1", rd1_b1, PAT_5);
    checkOutput("indep_rd2_b1", rd2_b1, PAT_A);

    // Fill every nonzero entry with its index and read back on both ports.
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b1, 5'(i), 64'(i), 5'd0, 5'd0);
      tick();
    end
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b0, 5'd0, 64'h0, 5'(i), 5'(i));
      checkOutput("fill_rd1_b0", rd1_b0, 64'(i));
      checkOutput("fill_rd2_b0", rd2_b0, 64'(i));
      checkOutput("fill_rd1_b1", rd1_b1, 64'(i));
    end

    // Same-cycle read/write of x3.
    applyStimulus(1'b1, 5'd3, 64'h1, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b1, 5'd3, 64'h2, 5'd3, 5'd4);
    checkOutput("same_pre_b0", rd1_b0, 64'h1);
    checkOutput("same_pre_b1", rd1_b1, 64'h2);
    checkOutput("same_other_b1", rd2_b1, 64'h4);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 5'd3, 5'd3);
    checkOutput("same_post_b0", rd1_b0, 64'h2);
    checkOutput("same_post_b1", rd1_b1, 64'h2);
    checkOutput("same_dual_b0", rd2_b0, 64'h2);

    // Asynchronous reset between edges, with a write attempted during it.
    applyStimulus(1'b1, 5'd1, PAT_A, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 5'd1, 5'd5);
    checkOutput("async_pre_b0", rd1_b0, PAT_A);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rd1_b0", rd1_b0, 64'h0);
    checkOutput("async_rd1_b1", rd1_b1, 64'h0);
    checkOutput("async_rd2_b0", rd2_b0, 64'h0);
    applyStimulus(1'b1, 5'd1, 64'h1234, 5'd1, 5'd5);
    checkOutput("async_nofwd_b1", rd1_b1, 64'h0);
    tick();
    checkOutput("async_wr_b0", rd1_b0, 64'h0);
    applyStimulus(1'b0, 5'd0, 64'h0, 5'd1, 5'd5);
    rst_n = 1'b1;
    #1;
    checkOutput("async_after_b0", rd1_b0, 64'h0);
    checkOutput("async_after_b1", rd1_b1, 64'h0);
    checkOutput("async_r5_b0", rd2_b0, 64'h0);

    // First write after reset release lands on the first edge.
    applyStimulus(1'b1, 5'd7, 64'hDEADBEEF, 5'd7, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 5'd7, 5'd7);
    checkOutput("first_wr_b0", rd1_b0, 64'hDEADBEEF);
    checkOutput("first_wr_b1", rd2_b1, 64'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
